// File: rtl/rv_muldiv_unit_if.sv
// rv_muldiv_unit_if: request/response bundle (START/OP/IS_W/A/B/KILL in, BUSY/DONE/RESULT out) for rv_muldiv_unit
interface rv_muldiv_unit_if #(parameter int XLEN = 64);
  logic            START;
  logic [2:0]      OP;
  logic            IS_W;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            KILL;
  logic            BUSY;
  logic            DONE;
  logic [XLEN-1:0] RESULT;
  modport master (output START, OP, IS_W, A, B, KILL, input BUSY, DONE, RESULT);
  modport slave (input START, OP, IS_W, A, B, KILL, output BUSY, DONE, RESULT);
endinterface

// File: rtl/rv_muldiv_unit.sv
// rv_muldiv_unit: iterative RV64M mul/div (shift-add, restoring divide); ports CLK, RST, bus (slave: START/OP/IS_W/A/B/KILL -> BUSY/DONE/RESULT)
module rv_muldiv_unit #(parameter int XLEN = 64) (
  input logic CLK,
  input logic RST,
  rv_muldiv_unit_if.slave bus
);
  localparam int W2 = 2 * XLEN;
  localparam int CW = $clog2(XLEN) + 1;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] op_q, op_d;
  logic w_q, w_d, neg_q, neg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W2-1:0] acc_q, acc_d, prod, div_nx;
  logic [XLEN-1:0] opd_q, opd_d, res_q, res_d;
  logic w_in, sgn_a, sgn_b, sa, sb, div0, ovf, accept, last, ge;
  logic [XLEN-1:0] ax, bx, ma, mb, min_n, dr, dv, raw;
  logic [W2:0] madd, msum, t;
  logic [XLEN:0] rem;
  function automatic logic [XLEN-1:0] fin(input logic w, input logic [XLEN-1:0] x);
    return w ? XLEN'($signed(x[31:0])) : x;
  endfunction
  always_comb begin
    w_in = (XLEN == 64) && bus.IS_W && !(bus.OP inside {3'd1, 3'd2, 3'd3});
    sgn_a = bus.OP inside {3'd1, 3'd2, 3'd4, 3'd6};
    sgn_b = bus.OP inside {3'd1, 3'd4, 3'd6};
    ax = w_in ? (sgn_a ? XLEN'($signed(bus.A[31:0])) : XLEN'(bus.A[31:0])) : bus.A;
    bx = w_in ? (sgn_b ? XLEN'($signed(bus.B[31:0])) : XLEN'(bus.B[31:0])) : bus.B;
    sa = sgn_a && ax[XLEN-1];
    sb = sgn_b && bx[XLEN-1];
    ma = sa ? -ax : ax;
    mb = sb ? -bx : bx;
    min_n = w_in ? ~XLEN'(32'h7fff_ffff) : {1'b1, {(XLEN-1){1'b0}}};
    div0 = bus.OP[2] && bx == '0;
    ovf = sgn_b && bus.OP[2] && ax == min_n && bx == '1;
    accept = bus.START && (state_q == S_IDLE || (state_q == S_DONE && !bus.KILL));
    last = cnt_q == CW'(w_q ? 31 : XLEN - 1);
    // the operand always enters the 2N-bit register at bit N
    madd = w_q ? (W2+1)'(opd_q) << 32 : (W2+1)'(opd_q) << XLEN;
    msum = {1'b0, acc_q} + (acc_q[0] ? madd : '0);
    t = {acc_q, 1'b0};
    rem = (XLEN+1)'(w_q ? t >> 32 : t >> XLEN);
    ge = rem >= {1'b0, opd_q};
    div_nx = W2'(ge ? (t - madd) | (W2+1)'(1) : t);
    prod = neg_q ? -acc_q : acc_q;
    dr = op_q[1] ? XLEN'(w_q ? acc_q >> 32 : acc_q >> XLEN) : acc_q[XLEN-1:0];
    dv = neg_q ? -dr : dr;
    raw = op_q[2] ? dv : (op_q[1:0] == 2'd0 ? prod[XLEN-1:0] : prod[W2-1:XLEN]);
    state_d = state_q;
    op_d = op_q;
    w_d = w_q;
    neg_d = neg_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    opd_d = opd_q;
    res_d = res_q;
    if (accept) begin
      op_d = bus.OP;
      w_d = w_in;
      cnt_d = '0;
      neg_d = (bus.OP[2] && bus.OP[1]) ? sa : sa ^ sb;
      acc_d = W2'(bus.OP[2] ? ma : mb);
      opd_d = bus.OP[2] ? mb : ma;
      state_d = (div0 || ovf) ? S_DONE : S_CALC;
      res_d = div0 ? fin(w_in, bus.OP[1] ? ax : '1) : ovf ? (bus.OP[1] ? '0 : ax) : res_q;
    end else if (state_q == S_CALC) begin
      acc_d = op_q[2] ? div_nx : msum[W2:1];
      cnt_d = cnt_q + 1'b1;
      state_d = bus.KILL ? S_IDLE : last ? S_FIX : S_CALC;
    end else if (state_q == S_FIX) begin
      res_d = bus.KILL ? res_q : fin(w_q, raw);
      state_d = bus.KILL ? S_IDLE : S_DONE;
    end else begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      op_q <= '0;
      w_q <= 1'b0;
      neg_q <= 1'b0;
      cnt_q <= '0;
      acc_q <= '0;
      opd_q <= '0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      w_q <= w_d;
      neg_q <= neg_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      opd_q <= opd_d;
      res_q <= res_d;
    end
  end
  assign bus.BUSY = state_q == S_CALC || state_q == S_FIX;
  assign bus.DONE = state_q == S_DONE;
  assign bus.RESULT = res_q;
endmodule

// File: tb/tb_rv_muldiv_unit.sv
// tb_rv_muldiv_unit: directed self-checking bench for rv_muldiv_unit
module tb_rv_muldiv_unit;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int errors = 0;
  int checks = 0;
  rv_muldiv_unit_if #(.XLEN(64)) bus();
  rv_muldiv_unit #(.XLEN(64)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;
  task automatic run_op(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b,
                        output int lat, output int busy_n, output logic [63:0] res);
    @(negedge CLK);
    bus.OP = op; bus.IS_W = w; bus.A = a; bus.B = b; bus.START = 1'b1;
    @(posedge CLK); #1;
    bus.START = 1'b0; bus.OP = ~op; bus.IS_W = ~w; bus.A = ~a; bus.B = ~b;
    lat = 1; busy_n = 0;
    while (!bus.DONE && lat < 200) begin
      busy_n += int'(bus.BUSY);
      @(posedge CLK); #1;
      lat++;
    end
    res = bus.RESULT;
  endtask
  task automatic test_reset();
    bus.START = 0; bus.OP = 0; bus.IS_W = 0; bus.A = 0; bus.B = 0; bus.KILL = 0; RST = 1;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.BUSY); end
    checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.DONE); end
    checks++; if (bus.RESULT !== 64'h0) begin errors++; $display("FAIL reset_result got %h exp 0", bus.RESULT); end
    RST = 0;
  endtask
  task automatic test_mul();
    int lat, bn;
    logic [63:0] r;
    run_op(3'd0, 1'b0, 64'd7, 64'hFFFFFFFFFFFFFFFD, lat, bn, r);
    checks++; if (lat !== 66) begin errors++; $display("FAIL mul_latency got %0d exp 66", lat); end
    checks++; if (bn !== 65) begin errors++; $display("FAIL mul_busy_cycles got %0d exp 65", bn); end
    checks++; if (r !== 64'hFFFFFFFFFFFFFFEB) begin errors++; $display("FAIL mul_result got %h exp FFFFFFFFFFFFFFEB", r); end
    @(posedge CLK); #1;
    checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL mul_done_pulse got %b exp 0", bus.DONE); end
    checks++; if (bus.RESULT !== 64'hFFFFFFFFFFFFFFEB) begin errors++; $display("FAIL mul_result_hold got %h exp FFFFFFFFFFFFFFEB", bus.RESULT); end
  endtask
  task automatic test_mulh();
    int lat, bn;
    logic [63:0] r;
    run_op(3'd3, 1'b0, '1, '1, lat, bn, r);
    checks++; if (r !== 64'hFFFFFFFFFFFFFFFE) begin errors++; $display("FAIL mulhu got %h exp FFFFFFFFFFFFFFFE", r); end
    run_op(3'd1, 1'b1, '1, '1, lat, bn, r);
    checks++; if (r !== 64'h0 || lat !== 66) begin errors++; $display("FAIL mulh got %h lat %0d exp 0 lat 66", r, lat); end
    run_op(3'd2, 1'b0, '1, 64'd2, lat, bn, r);
    checks++; if (r !== 64'hFFFFFFFFFFFFFFFF) begin errors++; $display("FAIL mulhsu got %h exp FFFFFFFFFFFFFFFF", r); end
  endtask
  task automatic test_special();
    logic [2:0] ops [4] = '{3'd4, 3'd6, 3'd4, 3'd6};
    logic [63:0] as [4] = '{64'd5, 64'd5, 64'h8000000000000000, 64'h8000000000000000};
    logic [63:0] bs [4] = '{64'd0, 64'd0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
    logic [63:0] ex [4] = '{64'hFFFFFFFFFFFFFFFF, 64'd5, 64'h8000000000000000, 64'd0};
    int lat, bn;
    logic [63:0] r;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], 1'b0, as[i], bs[i], lat, bn, r);
      checks++; if (lat !== 1) begin errors++; $display("FAIL special%0d_latency got %0d exp 1", i, lat); end
      checks++; if (bn !== 0) begin errors++; $display("FAIL special%0d_busy got %0d exp 0", i, bn); end
      checks++; if (r !== ex[i]) begin errors++; $display("FAIL special%0d_result got %h exp %h", i, r, ex[i]); end
    end
  endtask
  task automatic test_word();
    logic [2:0] ops [3] = '{3'd4, 3'd6, 3'd5};
    logic [63:0] ex [3] = '{64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFFF, 64'h000000007FFFFFFC};
    int lat, bn;
    logic [63:0] r;
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], 1'b1, 64'h12345678FFFFFFF9, 64'd2, lat, bn, r);
      checks++; if (lat !== 34) begin errors++; $display("FAIL word%0d_latency got %0d exp 34", i, lat); end
      checks++; if (r !== ex[i]) begin errors++; $display("FAIL word%0d_result got %h exp %h", i, r, ex[i]); end
    end
  endtask
  task automatic test_back_to_back();
    int pulses = 0, e1 = 0, e2 = 0;
    logic [63:0] r1 = '0, r2 = '0;
    @(negedge CLK);
    bus.OP = 3'd5; bus.IS_W = 0; bus.A = 64'd100; bus.B = 64'd7; bus.START = 1;
    @(posedge CLK); #1;
    for (int e = 1; e < 200; e++) begin
      if (bus.DONE) begin
        pulses++;
        if (pulses == 1) begin r1 = bus.RESULT; e1 = e; bus.OP = 3'd7; end
        else begin r2 = bus.RESULT; e2 = e; bus.START = 0; end
      end
      @(posedge CLK); #1;
    end
    bus.START = 0;
    checks++; if (r1 !== 64'd14) begin errors++; $display("FAIL b2b_divu got %0d exp 14", r1); end
    checks++; if (r2 !== 64'd2) begin errors++; $display("FAIL b2b_remu got %0d exp 2", r2); end
    checks++; if (pulses !== 2) begin errors++; $display("FAIL b2b_pulses got %0d exp 2", pulses); end
    checks++; if (e2 - e1 !== 66) begin errors++; $display("FAIL b2b_gap got %0d exp 66", e2 - e1); end
  endtask
  task automatic test_ignore();
    int pulses = 0, e1 = 0;
    logic [63:0] r = '0;
    @(negedge CLK);
    bus.OP = 3'd5; bus.IS_W = 0; bus.A = 64'd100; bus.B = 64'd7; bus.START = 1;
    @(posedge CLK); #1;
    bus.START = 0;
    for (int e = 1; e < 150; e++) begin
      if (e == 10) begin bus.START = 1; bus.OP = 3'd0; bus.A = 64'd3; bus.B = 64'd3; end
      if (e == 11) bus.START = 0;
      if (bus.DONE) begin pulses++; if (pulses == 1) begin r = bus.RESULT; e1 = e; end end
      @(posedge CLK); #1;
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL ignore_pulses got %0d exp 1", pulses); end
    checks++; if (e1 !== 66) begin errors++; $display("FAIL ignore_latency got %0d exp 66", e1); end
    checks++; if (r !== 64'd14) begin errors++; $display("FAIL ignore_result got %0d exp 14", r); end
  endtask
  task automatic test_kill();
    int pulses = 0;
    @(negedge CLK);
    bus.OP = 3'd4; bus.IS_W = 0; bus.A = 64'd1000; bus.B = 64'd9; bus.START = 1;
    @(posedge CLK); #1;
    bus.START = 0;
    repeat (9) begin @(posedge CLK); #1; end
    bus.KILL = 1;
    @(posedge CLK); #1;
    bus.KILL = 0;
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL kill_busy got %b exp 0", bus.BUSY); end
    checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL kill_done got %b exp 0", bus.DONE); end
    checks++; if (bus.RESULT !== 64'd14) begin errors++; $display("FAIL kill_result got %0d exp 14", bus.RESULT); end
    for (int e = 0; e < 80; e++) begin pulses += int'(bus.DONE); @(posedge CLK); #1; end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL kill_no_done got %0d exp 0", pulses); end
  endtask
  task automatic test_rst_mid();
    int lat, bn;
    logic [63:0] r;
    @(negedge CLK);
    bus.OP = 3'd0; bus.IS_W = 0; bus.A = 64'd11; bus.B = 64'd13; bus.START = 1;
    @(posedge CLK); #1;
    bus.START = 0;
    repeat (20) begin @(posedge CLK); #1; end
    RST = 1;
    @(posedge CLK); #1;
    checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", bus.BUSY); end
    checks++; if (bus.DONE !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %b exp 0", bus.DONE); end
    checks++; if (bus.RESULT !== 64'h0) begin errors++; $display("FAIL rst_mid_result got %h exp 0", bus.RESULT); end
    RST = 0;
    run_op(3'd0, 1'b0, 64'd6, 64'd7, lat, bn, r);
    checks++; if (lat !== 66) begin errors++; $display("FAIL rst_mul_latency got %0d exp 66", lat); end
    checks++; if (r !== 64'd42) begin errors++; $display("FAIL rst_mul_result got %0d exp 42", r); end
  endtask
  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_special();
    test_word();
    test_back_to_back();
    test_ignore();
    test_kill();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rv_muldiv_unit.md
Name: rv_muldiv_unit

Overview:
- Iterative RV64M multiply/divide unit attached to the multicycle datapath next to ula64, parametrised in XLEN.
- Adds the M extension: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, plus the RV64 word forms (MULW/DIVW/DIVUW/REMW/REMUW) selected by IS_W.
- The control FSM raises START, stalls on BUSY, and writes RESULT into AluOut when DONE pulses.
- Processing is one bit per cycle: shift-add multiply and restoring divide.

Parameters:
- XLEN, 64, operand/result width. Legal values are 32 and 64. IS_W is honoured only when XLEN=64.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- START  in  1  operation request; sampled only in IDLE or DONE state
- OP  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- IS_W  in  1  word form (RV64 *W); for MULH* it is ignored, treated as 0
- A  in  XLEN  rs1 operand, captured at START
- B  in  XLEN  rs2 operand, captured at START
- KILL  in  1  abort the operation in flight
- BUSY  out  1  high in CALC and FIX states
- DONE  out  1  one-cycle result-valid pulse
- RESULT  out  XLEN  result; holds its value until the next accepted START

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is synchronous and active-high. RST has priority over everything; after reset: state=IDLE, BUSY=0, DONE=0, RESULT=0, counter=0.
- States: IDLE, CALC, FIX, DONE.
- Operation accept: START is accepted in IDLE or DONE (back-to-back allowed). START is ignored in CALC and FIX. On acceptance, OP, IS_W, A and B are latched; later changes to the inputs have no effect.
- Width N: N=32 if IS_W, else XLEN. For word forms, operands are taken from bits [31:0]:
  - DIVW/REMW/MULW: bits [31:0] sign-extended.
  - DIVUW/REMUW: bits [31:0] zero-extended.
  - The 32-bit result is sign-extended to XLEN.
- Special cases, detected at acceptance; the next state is DONE directly (latency 1 edge):
  - Divide by zero (B[N-1:0]==0): DIV/DIVU quotient = all ones; REM/REMU = dividend (sign-extended for W forms).
  - Signed overflow (A = most-negative N-bit value, B = -1, DIV/REM): quotient = A; remainder = 0.
- Normal path: accept → CALC with counter=0.
  - CALC performs one iteration per cycle on operand magnitudes (signed ops use absolute values; MULHSU takes |A| with B unsigned).
  - After exactly N CALC cycles → FIX, which applies sign correction:
    - Product is negated if sign(A) xor sign(B), using a 2N-bit negate.
    - Quotient is negated if signs differ.
    - Remainder takes the dividend's sign.
  - FIX → DONE. DONE is high for exactly one cycle with RESULT valid.
  - Total latency: START edge to DONE = N+2 edges (66 for XLEN=64, 34 for W forms or XLEN=32).
- Result selection:
  - MUL: product[N-1:0].
  - MULH/MULHSU/MULHU: product[2N-1:N].
  - DIV*: quotient. REM*: remainder.
- DONE → IDLE on the next edge unless START is accepted. RESULT is unchanged across that transition.
- KILL: in CALC or FIX, the next state is IDLE. DONE does not pulse and RESULT keeps its previous value. KILL in IDLE/DONE has no effect. KILL and START together in DONE: KILL wins and START is dropped.
- Datapath width: one 2N-bit accumulator/remainder register, one N-bit operand shift register, a log2(XLEN)+1-bit counter. No combinational full multiplier.

Test Plan:
- Reset, then MUL A=7, B=-3 (0xFFFFFFFFFFFFFFFD) → BUSY high for 65 cycles; DONE at edge 66; RESULT=0xFFFFFFFFFFFFFFEB. Next cycle DONE=0 and RESULT is held.
- MULHU A=B=0xFFFFFFFFFFFFFFFF → RESULT=0xFFFFFFFFFFFFFFFE. MULH on the same operands → 0x0000000000000000. MULHSU A=-1, B=2 → 0xFFFFFFFFFFFFFFFF.
- Special cases, all with DONE at edge 1 and BUSY never high:
  - DIV A=5, B=0 → 0xFFFFFFFFFFFFFFFF.
  - REM A=5, B=0 → 5.
  - DIV A=0x8000000000000000, B=-1 → 0x8000000000000000.
  - REM on the same operands → 0.
- DIVW A=0x12345678FFFFFFF9, B=2 → 0xFFFFFFFFFFFFFFFD at edge 34. REMW → 0xFFFFFFFFFFFFFFFF. DIVUW with the same operands → 0x000000007FFFFFFC.
- Back-to-back: START held high through DONE with DIVU 100/7 then REMU 100/7 → first RESULT=14, second=2. START pulsed during CALC is ignored (exactly two DONE pulses).
- Abort: KILL at CALC cycle 10 → IDLE with no DONE and RESULT unchanged. Separately, RST mid-CALC → all outputs 0 on the next edge, and a new MUL completes normally afterwards.
